clk_div_ctrl: RTL and testbench

Run-time programmable clock-divider controller producing a registered divided clock enable/waveform `clk_out` with configurable period (DIV) and high time (HIGH).
- Owns the period counter and the run/stop sequencing.
- Accepts new DIV/HIGH settings over a valid/ready handshake.
- Applies new settings only at period boundaries, so `clk_out` never shows a truncated or runt pulse.
- Sits between the system config logic and the divided-clock consumers.

---
 rtl/clk_div_ctrl_if.sv | 20 ++
 rtl/clk_div_ctrl.sv | 106 ++++++++++
 tb/tb_clk_div_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake between the system config logic and clk_div_ctrl.
interface clk_div_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_div, cfg_high,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_high,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider with boundary-aligned config updates.
// Optional CLKDIV_PERIOD_CNT_EN adds a saturating 16-bit period counter output.
module clk_div_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned DEF_DIV  = 10,
    parameter int unsigned DEF_HIGH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    clk_div_ctrl_if.slave    cfg,
    output logic             clk_out,
    output logic             period_tick,
    output logic             active,
    output logic [CNT_W-1:0] div_cur,
    output logic [CNT_W-1:0] high_cur
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, PEND, DRAIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_high;
    logic             pending;
    logic             wrap;
    logic             legal;
    logic             offer;
    logic             accept;

    assign cfg.cfg_ready = (state == IDLE) || (state == RUN);
    assign active        = (state != IDLE);

    always_comb begin
        wrap   = (cnt == div_cur - CNT_W'(1));
        legal  = (cfg.cfg_div >= CNT_W'(2)) && (cfg.cfg_high != '0) &&
                 (cfg.cfg_high < cfg.cfg_div);
        offer  = cfg.cfg_valid && cfg.cfg_ready;
        accept = offer && legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            div_cur     <= CNT_W'(DEF_DIV);
            high_cur    <= CNT_W'(DEF_HIGH);
            pend_div    <= '0;
            pend_high   <= '0;
            pending     <= 1'b0;
            clk_out     <= 1'b0;
            period_tick <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            clk_out     <= (state != IDLE) && (cnt < high_cur);
            period_tick <= (state != IDLE) && (cnt == '0);
            cfg.cfg_err <= offer && !legal;

            if (state == IDLE) begin
                cnt <= '0;
                if (accept) begin
                    div_cur  <= cfg.cfg_div;
                    high_cur <= cfg.cfg_high;
                end
                if (en) state <= RUN;
            end else if (wrap) begin
                // Period boundary: pending settings (or one offered right now) start the next period.
                cnt     <= '0;
                pending <= 1'b0;
                if (pending) begin
                    div_cur  <= pend_div;
                    high_cur <= pend_high;
                end else if (accept) begin
                    div_cur  <= cfg.cfg_div;
                    high_cur <= cfg.cfg_high;
                end
                state <= en ? RUN : IDLE;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (accept) begin
                    pend_div  <= cfg.cfg_div;
                    pend_high <= cfg.cfg_high;
                    pending   <= 1'b1;
                end
                if (!en)                      state <= DRAIN;
                else if (pending || accept)   state <= PEND;
                else                          state <= RUN;
            end
        end
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (state == IDLE && en) begin
            period_cnt <= '0;
        end else if (state != IDLE && cnt == '0 && period_cnt != 16'hFFFF) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected clk_out/period_tick streams are queued at drive time.
module tb_clk_div_ctrl;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             clk_out;
    logic             period_tick;
    logic             active;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] high_cur;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0]      period_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int sample = 0;

    typedef struct packed {
        logic co;
        logic tk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    clk_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(10), .DEF_HIGH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg         (cfg_if),
        .clk_out     (clk_out),
        .period_tick (period_tick),
        .active      (active),
        .div_cur     (div_cur),
        .high_cur    (high_cur)
`ifdef CLKDIV_PERIOD_CNT_EN
        ,
        .period_cnt  (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: one queued expectation per rising edge, sampled just after the edge.
    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            sample++;
            checks++;
            if (clk_out !== mon_e.co || period_tick !== mon_e.tk) begin
                errors++;
                $display("FAIL wave[%0d]: clk_out=%b period_tick=%b, expected %b %b",
                         sample, clk_out, period_tick, mon_e.co, mon_e.tk);
            end
        end
    end

    function automatic string rep(string s, int n);
        string r;
        r = "";
        for (int i = 0; i < n; i++) r = {r, s};
        return r;
    endfunction

    task automatic push_wave(string co, string tk);
        for (int i = 0; i < co.len(); i++)
            exp_q.push_back(exp_t'({co[i] == "1", tk[i] == "1"}));
    endtask

    function automatic logic [18:0] status();
        return {cfg_if.cfg_err, cfg_if.cfg_ready, active, div_cur, high_cur};
    endfunction

    function automatic logic [18:0] exp_st(bit err, bit rdy, bit act, int d, int h);
        logic [7:0] dv, hv;
        dv = d[7:0];
        hv = h[7:0];
        return {err, rdy, act, dv, hv};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        en = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div = '0;
        cfg_if.cfg_high = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [18:0] want;
        rst_n = 1'b0;
        en = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div = '0;
        cfg_if.cfg_high = '0;
        @(negedge clk);
        checks++;
        if ({clk_out, period_tick} !== 2'b00) begin
            errors++;
            $display("FAIL reset_wave: clk_out/tick=%b, expected 00", {clk_out, period_tick});
        end
        want = exp_st(0, 1, 0, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL reset_status: status=%h expected %h", status(), want);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_default();
        logic [18:0] want;
        apply_reset();
        push_wave({"0", rep("1111000000", 3)}, {"0", rep("1000000000", 3)});
        en = 1'b1;
        cyc();
        want = exp_st(0, 1, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL default_enter: status=%h expected %h", status(), want);
        end
        repeat (30) cyc();
        checks++;
        if (status() !== want || exp_q.size() != 0) begin
            errors++;
            $display("FAIL default_end: status=%h left=%0d expected %h left=0", status(), exp_q.size(), want);
        end
    endtask

    task automatic test_cfg_pend();
        logic [18:0] want;
        apply_reset();
        push_wave({"0", "1111000000", rep("100", 4)}, {"0", "1000000000", rep("100", 4)});
        en = 1'b1;
        repeat (6) cyc();
        want = exp_st(0, 1, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL pend_before: status=%h expected %h", status(), want);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd3;
        cfg_if.cfg_high = 8'd1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        want = exp_st(0, 0, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL pend_accept: status=%h expected %h", status(), want);
        end
        repeat (3) cyc();
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL pend_hold: status=%h expected %h", status(), want);
        end
        cyc();
        want = exp_st(0, 1, 1, 3, 1);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL pend_apply: status=%h expected %h", status(), want);
        end
        repeat (12) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pend_drain: left=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_cfg_err();
        logic [18:0] want;
        apply_reset();
        push_wave({"0", rep("1111000000", 3)}, {"0", rep("1000000000", 3)});
        en = 1'b1;
        repeat (3) cyc();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd1;
        cfg_if.cfg_high = 8'd0;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        want = exp_st(1, 1, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL err_div1: status=%h expected %h", status(), want);
        end
        cyc();
        want = exp_st(0, 1, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL err_pulse1: status=%h expected %h", status(), want);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd4;
        cfg_if.cfg_high = 8'd4;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        want = exp_st(1, 1, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL err_high_eq_div: status=%h expected %h", status(), want);
        end
        cyc();
        want = exp_st(0, 1, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL err_pulse2: status=%h expected %h", status(), want);
        end
        repeat (24) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL err_drain: left=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_drain();
        logic [18:0] want;
        apply_reset();
        push_wave({"0", "1111000000", "000"}, {"0", "1000000000", "000"});
        en = 1'b1;
        repeat (3) cyc();
        en = 1'b0;
        cyc();
        want = exp_st(0, 0, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL drain_enter: status=%h expected %h", status(), want);
        end
        repeat (6) cyc();
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL drain_last: status=%h expected %h", status(), want);
        end
        cyc();
        want = exp_st(0, 1, 0, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL drain_idle: status=%h expected %h", status(), want);
        end
        repeat (3) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_left: left=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_drain_resume();
        logic [18:0] want;
        apply_reset();
        push_wave({"0", rep("1111000000", 3)}, {"0", rep("1000000000", 3)});
        en = 1'b1;
        repeat (3) cyc();
        en = 1'b0;
        cyc();
        want = exp_st(0, 0, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL resume_drain: status=%h expected %h", status(), want);
        end
        repeat (2) cyc();
        en = 1'b1;
        cyc();
        want = exp_st(0, 1, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL resume_run: status=%h expected %h", status(), want);
        end
        repeat (24) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL resume_left: left=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_idle_cfg();
        logic [18:0] want;
        apply_reset();
        push_wave({"0", rep("111000", 3)}, {"0", rep("100000", 3)});
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd6;
        cfg_if.cfg_high = 8'd3;
        en = 1'b1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        want = exp_st(0, 1, 1, 6, 3);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL idle_cfg: status=%h expected %h", status(), want);
        end
        repeat (18) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL idle_cfg_left: left=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_min_div();
        logic [18:0] want;
        apply_reset();
        push_wave({"0", rep("10", 5)}, {"0", rep("10", 5)});
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd2;
        cfg_if.cfg_high = 8'd1;
        en = 1'b1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        want = exp_st(0, 1, 1, 2, 1);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL min_div: status=%h expected %h", status(), want);
        end
        repeat (10) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL min_div_left: left=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_pend();
        logic [18:0] want;
        apply_reset();
        push_wave("01", "01");
        en = 1'b1;
        cyc();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd3;
        cfg_if.cfg_high = 8'd1;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        want = exp_st(0, 0, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL rst_pend: status=%h expected %h", status(), want);
        end
        #2;
        rst_n = 1'b0;
        #1;
        want = exp_st(0, 1, 0, 10, 4);
        checks++;
        if ({clk_out, period_tick} !== 2'b00 || status() !== want) begin
            errors++;
            $display("FAIL rst_async: clk_out/tick=%b status=%h expected 00 %h",
                     {clk_out, period_tick}, status(), want);
        end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef CLKDIV_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'd0) begin
            errors++;
            $display("FAIL pcnt_reset: period_cnt=%0d expected 0", period_cnt);
        end
`endif
        push_wave({"0", rep("1111000000", 3)}, {"0", rep("1000000000", 3)});
        en = 1'b1;
        repeat (2) cyc();
`ifdef CLKDIV_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pcnt_1: period_cnt=%0d expected 1", period_cnt);
        end
`endif
        repeat (10) cyc();
        want = exp_st(0, 1, 1, 10, 4);
        checks++;
        if (status() !== want) begin
            errors++;
            $display("FAIL rst_pend_lost: status=%h expected %h", status(), want);
        end
`ifdef CLKDIV_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'd2) begin
            errors++;
            $display("FAIL pcnt_2: period_cnt=%0d expected 2", period_cnt);
        end
`endif
        repeat (10) cyc();
`ifdef CLKDIV_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'd3) begin
            errors++;
            $display("FAIL pcnt_3: period_cnt=%0d expected 3", period_cnt);
        end
`endif
        repeat (9) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_left: left=%0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_cfg_pend();
        test_cfg_err();
        test_drain();
        test_drain_resume();
        test_idle_cfg();
        test_min_div();
        test_reset_mid_pend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
